// File: rtl/im_arbiter.sv
// Shares the single instruction-memory read port between IF and LS: checks addresses,
// gives LS priority with bounded IF starvation, and returns registered data one cycle later.
module im_arbiter #(
    parameter int unsigned NBIT       = 10,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_ack,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        ls_req,
    input  logic [31:0] ls_addr,
    output logic        ls_ack,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,
    output logic        ls_err,
    output logic [31:0] im_addr,
    input  logic [31:0] im_data
);
    localparam int unsigned      CNT_W      = 4;
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
    localparam logic [31:0]      SAFE_ADDR  = 32'h9fc0_0000;
    // Bits between the segment tag and the word index that must be zero
    localparam logic [31:0]      ZERO_MASK  = 32'h000f_ffff & ~((32'h1 << (NBIT + 2)) - 32'h1);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_LS
    } owner_e;

    owner_e           r_owner;
    owner_e           w_owner_nxt;
    logic [CNT_W-1:0] r_starve;
    logic [31:0]      r_if_rdata;
    logic             r_if_err;
    logic [31:0]      r_ls_rdata;
    logic             r_ls_err;

    logic             w_if_win;
    logic             w_ls_win;
    logic             w_grant;
    logic             w_addr_ok;
    logic [31:0]      w_gnt_addr;
    logic [31:0]      w_rdata;

    function automatic logic addr_valid(input logic [31:0] a);
        return ((a[31:20] == 12'h9fc) || (a[31:20] == 12'h800))
            && ((a & ZERO_MASK) == 32'h0)
            && (a[1:0] == 2'b00);
    endfunction

    // LS has priority until IF has been denied STARVE_MAX cycles in a row
    assign w_if_win   = if_req && (!ls_req || (r_starve == STARVE_LIM));
    assign w_ls_win   = ls_req && !w_if_win;
    assign w_grant    = w_if_win || w_ls_win;
    assign w_gnt_addr = w_if_win ? if_addr : ls_addr;
    assign w_addr_ok  = addr_valid(w_gnt_addr);
    assign w_rdata    = w_addr_ok ? im_data : 32'h0;

    assign if_ack     = w_if_win;
    assign ls_ack     = w_ls_win;
    assign im_addr    = (w_grant && w_addr_ok) ? w_gnt_addr : SAFE_ADDR;

    assign if_rvalid  = (r_owner == OWN_IF);
    assign ls_rvalid  = (r_owner == OWN_LS);
    assign if_rdata   = r_if_rdata;
    assign if_err     = r_if_err;
    assign ls_rdata   = r_ls_rdata;
    assign ls_err     = r_ls_err;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_owner <= OWN_NONE;
        end else begin
            r_owner <= w_owner_nxt;
        end
    end

    // A flushed IF grant still uses the port but owns no response
    always_comb begin
        w_owner_nxt = OWN_NONE;
        if (w_if_win && !if_flush) begin
            w_owner_nxt = OWN_IF;
        end else if (w_ls_win) begin
            w_owner_nxt = OWN_LS;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_starve <= '0;
        end else if (!if_req || w_if_win) begin
            r_starve <= '0;
        end else if (r_starve != STARVE_LIM) begin
            r_starve <= r_starve + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_if_rdata <= 32'h0;
            r_if_err   <= 1'b0;
            r_ls_rdata <= 32'h0;
            r_ls_err   <= 1'b0;
        end else begin
            if (w_if_win && !if_flush) begin
                r_if_rdata <= w_rdata;
                r_if_err   <= !w_addr_ok;
            end
            if (w_ls_win) begin
                r_ls_rdata <= w_rdata;
                r_ls_err   <= !w_addr_ok;
            end
        end
    end

endmodule

// File: tb/tb_im_arbiter.sv
// Self-checking bench for im_arbiter: directed vector table, hand-written multi-cycle
// sequences, and a randomized run against a rule-level reference model.
module tb_im_arbiter;
    localparam int unsigned NBIT       = 10;
    localparam int unsigned STARVE_MAX = 4;
    localparam int unsigned WORDS      = 1 << NBIT;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        if_flush = 1'b0;
    logic        if_ack;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        ls_req = 1'b0;
    logic [31:0] ls_addr = 32'h0;
    logic        ls_ack;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        ls_err;
    logic [31:0] im_addr;
    logic [31:0] im_data;

    logic [31:0] boot_mem [WORDS];
    logic [31:0] ram_mem  [WORDS];

    int total = 0;
    int bad   = 0;

    im_arbiter #(.NBIT(NBIT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .resetn(resetn),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_ack(if_ack),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .ls_req(ls_req), .ls_addr(ls_addr), .ls_ack(ls_ack),
        .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
        .im_addr(im_addr), .im_data(im_data)
    );

    always #5 clk = ~clk;

    // Combinational instruction memory: two segments selected by the tag
    always_comb begin
        if (im_addr[31:20] == 12'h800) im_data = ram_mem[im_addr[NBIT+1:2]];
        else                           im_data = boot_mem[im_addr[NBIT+1:2]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit ref_valid(input logic [31:0] a);
        logic [31:0] seg;
        logic [31:0] off;
        seg = {20'h0, a[31:20]};
        off = {12'h0, a[19:0]};
        return (seg == 32'h9fc || seg == 32'h800) && (off < 4 * WORDS) && (off % 4 == 0);
    endfunction

    function automatic logic [31:0] ref_data(input logic [31:0] a);
        logic [31:0] idx;
        if (!ref_valid(a)) return 32'h0;
        idx = {12'h0, a[19:0]} / 4;
        if (a[31:20] == 12'h800) return ram_mem[idx[NBIT-1:0]];
        return boot_mem[idx[NBIT-1:0]];
    endfunction

    function automatic logic [31:0] rand_addr();
        int unsigned sel;
        logic [31:0] r;
        sel = $urandom_range(0, 7);
        r   = $urandom;
        if (sel < 3)       return 32'h9fc0_0000 | ((r % WORDS) * 4);
        else if (sel < 6)  return 32'h8000_0000 | ((r % WORDS) * 4);
        else if (sel == 6) return r & ~32'h3;
        return 32'h8000_0000 | (r & 32'h000f_ffff);
    endfunction

    // Requester protocol: address must stay stable while a request waits for its ack
    logic        pa_if_pend = 1'b0;
    logic        pa_ls_pend = 1'b0;
    logic [31:0] pa_if_addr = 32'h0;
    logic [31:0] pa_ls_addr = 32'h0;
    always @(posedge clk) begin
        if (!resetn) begin
            pa_if_pend = 1'b0;
            pa_ls_pend = 1'b0;
        end else begin
            if (pa_if_pend && if_req) assert (if_addr == pa_if_addr) else $error("if_addr changed while pending");
            if (pa_ls_pend && ls_req) assert (ls_addr == pa_ls_addr) else $error("ls_addr changed while pending");
            pa_if_pend = if_req && !if_ack;
            pa_ls_pend = ls_req && !ls_ack;
            pa_if_addr = if_addr;
            pa_ls_addr = ls_addr;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        if_flush;
        logic        ls_req;
        logic [31:0] ls_addr;
        logic        e_if_ack;
        logic        e_ls_ack;
        logic [31:0] e_im_addr;
        logic        e_if_rv;
        logic [31:0] e_if_rdata;
        logic        e_if_err;
        logic        e_ls_rv;
        logic [31:0] e_ls_rdata;
        logic        e_ls_err;
    } vec_t;

    vec_t vecs [9];

    initial begin
        for (int i = 0; i < int'(WORDS); i++) begin
            boot_mem[i] = $urandom;
            ram_mem[i]  = $urandom;
        end
        boot_mem[1] = 32'h3c08_bfc0;
        boot_mem[2] = 32'h1111_2222;
        ram_mem[2]  = 32'h3333_4444;
        ram_mem[4]  = 32'haaaa_5555;

        //            if_req addr          flush  ls_req addr         ifack lsack im_addr       ifrv  ifdata        iferr  lsrv  lsdata        lserr
        vecs[0] = '{1'b1, 32'h9fc00004, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h9fc00004, 1'b1, 32'h3c08bfc0, 1'b0, 1'b0, 32'h0,        1'b0};
        vecs[1] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h80000008, 1'b0, 1'b1, 32'h80000008, 1'b0, 32'h0,        1'b0, 1'b1, 32'h33334444, 1'b0};
        vecs[2] = '{1'b1, 32'h9fc00008, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h9fc00008, 1'b1, 32'h11112222, 1'b0, 1'b0, 32'h0,        1'b0};
        vecs[3] = '{1'b1, 32'hbfc00000, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h9fc00000, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0};
        vecs[4] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h80001000, 1'b0, 1'b1, 32'h9fc00000, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b1};
        vecs[5] = '{1'b1, 32'h80000002, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h9fc00000, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0};
        vecs[6] = '{1'b1, 32'h9fc00004, 1'b0, 1'b1, 32'h80000008, 1'b0, 1'b1, 32'h80000008, 1'b0, 32'h0,        1'b0, 1'b1, 32'h33334444, 1'b0};
        vecs[7] = '{1'b1, 32'h80000010, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h80000010, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0};
        vecs[8] = '{1'b1, 32'h80000000, 1'b1, 1'b1, 32'h9fc00008, 1'b0, 1'b1, 32'h9fc00008, 1'b0, 32'h0,        1'b0, 1'b1, 32'h11112222, 1'b0};

        // Reset state
        @(negedge clk);
        check("rst_if_rvalid", if_rvalid, 0);
        check("rst_ls_rvalid", ls_rvalid, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_ls_rdata", ls_rdata, 0);
        check("rst_if_err", if_err, 0);
        check("rst_ls_err", ls_err, 0);
        check("rst_acks", {if_ack, ls_ack}, 0);
        check("rst_im_addr", im_addr, 32'h9fc00000);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Directed single-grant vectors, each followed by an idle cycle
        for (int i = 0; i < 9; i++) begin
            if_req = vecs[i].if_req; if_addr = vecs[i].if_addr; if_flush = vecs[i].if_flush;
            ls_req = vecs[i].ls_req; ls_addr = vecs[i].ls_addr;
            #1;
            check($sformatf("vec%0d_if_ack", i), if_ack, vecs[i].e_if_ack);
            check($sformatf("vec%0d_ls_ack", i), ls_ack, vecs[i].e_ls_ack);
            check($sformatf("vec%0d_im_addr", i), im_addr, vecs[i].e_im_addr);
            @(negedge clk);
            if_req = 1'b0; ls_req = 1'b0; if_flush = 1'b0;
            check($sformatf("vec%0d_if_rvalid", i), if_rvalid, vecs[i].e_if_rv);
            check($sformatf("vec%0d_ls_rvalid", i), ls_rvalid, vecs[i].e_ls_rv);
            if (vecs[i].e_if_rv) begin
                check($sformatf("vec%0d_if_rdata", i), if_rdata, vecs[i].e_if_rdata);
                check($sformatf("vec%0d_if_err", i), if_err, vecs[i].e_if_err);
            end
            if (vecs[i].e_ls_rv) begin
                check($sformatf("vec%0d_ls_rdata", i), ls_rdata, vecs[i].e_ls_rdata);
                check($sformatf("vec%0d_ls_err", i), ls_err, vecs[i].e_ls_err);
            end
            @(negedge clk);
        end

        // Flushed IF grant followed by a normal IF request
        if_req = 1'b1; if_addr = 32'h80000010; if_flush = 1'b1;
        #1 check("flush_ack0", if_ack, 1);
        @(negedge clk);
        if_flush = 1'b0;
        check("flush_no_rvalid", if_rvalid, 0);
        #1 check("flush_ack1", if_ack, 1);
        @(negedge clk);
        if_req = 1'b0;
        check("flush_second_rvalid", if_rvalid, 1);
        check("flush_second_rdata", if_rdata, 32'haaaa5555);
        check("flush_second_err", if_err, 0);
        @(negedge clk);

        // Partial starvation, then reset right after an LS ack
        if_req = 1'b1; if_addr = 32'h9fc00004;
        ls_req = 1'b1; ls_addr = 32'h80000008;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("pre_rst_ls_ack", ls_ack, 1);
            check("pre_rst_if_ack", if_ack, 0);
            if (k < 2) @(negedge clk);
            else       @(posedge clk);
        end
        #1;
        resetn = 1'b0; if_req = 1'b0; ls_req = 1'b0;
        #1;
        check("midrst_ls_rvalid", ls_rvalid, 0);
        check("midrst_if_rvalid", if_rvalid, 0);
        check("midrst_ls_rdata", ls_rdata, 0);
        check("midrst_if_rdata", if_rdata, 0);
        check("midrst_errs", {if_err, ls_err}, 0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;

        // Contention from a fresh counter: four LS grants then one IF grant, repeating
        if_req = 1'b1; ls_req = 1'b1;
        begin
            logic prev_if;
            logic prev_ls;
            logic win_if;
            prev_if = 1'b0; prev_ls = 1'b0;
            for (int k = 0; k < 15; k++) begin
                check("cont_if_rvalid", if_rvalid, prev_if);
                check("cont_ls_rvalid", ls_rvalid, prev_ls);
                if (prev_if) check("cont_if_rdata", if_rdata, 32'h3c08bfc0);
                if (prev_ls) check("cont_ls_rdata", ls_rdata, 32'h33334444);
                win_if = (k % 5 == 4);
                #1;
                check($sformatf("cont%0d_if_ack", k), if_ack, win_if);
                check($sformatf("cont%0d_ls_ack", k), ls_ack, !win_if);
                check($sformatf("cont%0d_im_addr", k), im_addr, win_if ? 32'h9fc00004 : 32'h80000008);
                prev_if = win_if; prev_ls = !win_if;
                @(negedge clk);
            end
            if_req = 1'b0; ls_req = 1'b0;
            check("cont_last_if_rvalid", if_rvalid, prev_if);
            check("cont_last_ls_rvalid", ls_rvalid, prev_ls);
            @(negedge clk);
        end

        // Randomized traffic against the reference model
        begin
            int unsigned denied;
            logic        pend_if, pend_ls, m_if_win, m_ls_win;
            logic        e_if_rv, e_ls_rv, e_if_err, e_ls_err;
            logic [31:0] e_if_rdata, e_ls_rdata, g_addr, e_im;
            denied = 0; pend_if = 1'b0; pend_ls = 1'b0;
            e_if_rv = 1'b0; e_ls_rv = 1'b0; e_if_err = 1'b0; e_ls_err = 1'b0;
            e_if_rdata = 32'h0; e_ls_rdata = 32'h0;
            for (int c = 0; c < 400; c++) begin
                check("rnd_if_rvalid", if_rvalid, e_if_rv);
                check("rnd_ls_rvalid", ls_rvalid, e_ls_rv);
                if (e_if_rv) begin
                    check("rnd_if_rdata", if_rdata, e_if_rdata);
                    check("rnd_if_err", if_err, e_if_err);
                end
                if (e_ls_rv) begin
                    check("rnd_ls_rdata", ls_rdata, e_ls_rdata);
                    check("rnd_ls_err", ls_err, e_ls_err);
                end
                if (!pend_if) begin
                    if_req  = ($urandom % 4) != 0;
                    if_addr = rand_addr();
                end
                if (!pend_ls) begin
                    ls_req  = ($urandom % 3) != 0;
                    ls_addr = rand_addr();
                end
                if_flush = ($urandom % 4) == 0;
                m_if_win = if_req && (!ls_req || denied == STARVE_MAX);
                m_ls_win = ls_req && !m_if_win;
                g_addr   = m_if_win ? if_addr : ls_addr;
                e_im     = ((m_if_win || m_ls_win) && ref_valid(g_addr)) ? g_addr : 32'h9fc00000;
                #1;
                check("rnd_if_ack", if_ack, m_if_win);
                check("rnd_ls_ack", ls_ack, m_ls_win);
                check("rnd_im_addr", im_addr, e_im);
                if (if_req && !m_if_win) denied = (denied < STARVE_MAX) ? denied + 1 : denied;
                else                     denied = 0;
                e_if_rv = m_if_win && !if_flush;
                e_ls_rv = m_ls_win;
                if (e_if_rv) begin
                    e_if_rdata = ref_data(if_addr);
                    e_if_err   = !ref_valid(if_addr);
                end
                if (e_ls_rv) begin
                    e_ls_rdata = ref_data(ls_addr);
                    e_ls_err   = !ref_valid(ls_addr);
                end
                pend_if = if_req && !m_if_win;
                pend_ls = ls_req && !m_ls_win;
                @(negedge clk);
            end
            if_req = 1'b0; ls_req = 1'b0; if_flush = 1'b0;
            check("rnd_final_if_rvalid", if_rvalid, e_if_rv);
            check("rnd_final_ls_rvalid", ls_rvalid, e_ls_rv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
